// File: rtl/mem_arbiter_2port.sv
// Two-requester memory arbiter: round-robin request grant onto one shared port,
// with an in-order ID FIFO that steers each response back to its requester.
module mem_arbiter_2port #(
  parameter int  p_opaq_bits    = 8,
  parameter type t_req_msg      = logic [p_opaq_bits+69:0],
  parameter type t_resp_msg     = logic [p_opaq_bits+39:0],
  parameter int  p_max_inflight = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] up_req_val,
  output logic [1:0] up_req_rdy,
  input  t_req_msg   up_req_msg [2],
  output logic [1:0] up_resp_val,
  input  logic [1:0] up_resp_rdy,
  output t_resp_msg  up_resp_msg [2],
  output logic       down_req_val,
  input  logic       down_req_rdy,
  output t_req_msg   down_req_msg,
  input  logic       down_resp_val,
  output logic       down_resp_rdy,
  input  t_resp_msg  down_resp_msg
);

  localparam int PTR_W = $clog2(p_max_inflight);
  localparam int CNT_W = PTR_W + 1;

  if (p_max_inflight < 2 || (p_max_inflight & (p_max_inflight - 1)) != 0) begin : g_bad_depth
    $error("p_max_inflight must be a power of 2 and at least 2");
  end

  logic             prio_reg, prio_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             id_mem [p_max_inflight];

  logic grant;
  logic head;
  logic full;
  logic empty;
  logic req_fire;
  logic resp_fire;

  always_comb begin
    // Contention resolves by prio; otherwise the lone valid port (port 0 if none).
    grant         = (up_req_val == 2'b11) ? prio_reg : up_req_val[1];
    full          = (count_reg == CNT_W'(p_max_inflight));
    empty         = (count_reg == '0);
    head          = id_mem[rd_ptr_reg];
    down_req_val  = rst & (|up_req_val) & ~full;
    down_req_msg  = up_req_msg[grant];
    req_fire      = down_req_val & down_req_rdy;
    down_resp_rdy = rst & ~empty & up_resp_rdy[head];
    resp_fire     = down_resp_val & down_resp_rdy;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign up_req_rdy[gi]  = rst & (grant == 1'(gi)) & down_req_rdy & ~full;
    assign up_resp_val[gi] = rst & down_resp_val & ~empty & (head == 1'(gi));
    assign up_resp_msg[gi] = down_resp_msg;
  end

  always_comb begin
    prio_next   = prio_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (req_fire) begin
      prio_next   = ~grant;
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (resp_fire) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({req_fire, resp_fire})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_reg   <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      prio_reg   <= prio_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // ID storage carries no reset; entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      id_mem[wr_ptr_reg] <= grant;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Directed self-checking bench for mem_arbiter_2port; one task per scenario.
module tb_mem_arbiter_2port;

  logic        clk;
  logic        rst;
  logic [1:0]  up_req_val;
  logic [1:0]  up_req_rdy;
  logic [77:0] up_req_msg [2];
  logic [1:0]  up_resp_val;
  logic [1:0]  up_resp_rdy;
  logic [47:0] up_resp_msg [2];
  logic        down_req_val;
  logic        down_req_rdy;
  logic [77:0] down_req_msg;
  logic        down_resp_val;
  logic        down_resp_rdy;
  logic [47:0] down_resp_msg;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter_2port dut (
    .clk           (clk),
    .rst           (rst),
    .up_req_val    (up_req_val),
    .up_req_rdy    (up_req_rdy),
    .up_req_msg    (up_req_msg),
    .up_resp_val   (up_resp_val),
    .up_resp_rdy   (up_resp_rdy),
    .up_resp_msg   (up_resp_msg),
    .down_req_val  (down_req_val),
    .down_req_rdy  (down_req_rdy),
    .down_req_msg  (down_req_msg),
    .down_resp_val (down_resp_val),
    .down_resp_rdy (down_resp_rdy),
    .down_resp_msg (down_resp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [77:0] mk_req(input logic [7:0] opq, input logic [31:0] addr);
    return {4'd0, opq, addr, 2'd0, 32'd0};
  endfunction

  function automatic logic [47:0] mk_resp(input logic [7:0] opq, input logic [31:0] data);
    return {4'd0, opq, 2'd0, 2'd0, data};
  endfunction

  function automatic logic [1:0] onehot(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    up_req_val    = 2'b00;
    up_req_msg[0] = '0;
    up_req_msg[1] = '0;
    up_resp_rdy   = 2'b00;
    down_req_rdy  = 1'b0;
    down_resp_val = 1'b0;
    down_resp_msg = '0;
  endtask

  task automatic test_reset();
    logic [77:0] req;
    logic [47:0] rsp;
    rst = 1'b0;
    up_req_val = 2'b11; down_req_rdy = 1'b1; down_resp_val = 1'b1; up_resp_rdy = 2'b11;
    #1;
    n_tests++; if (down_req_val !== 1'b0) begin n_fail++; $display("FAIL rst_down_req_val: got %b want 0", down_req_val); end
    n_tests++; if (up_req_rdy !== 2'b00) begin n_fail++; $display("FAIL rst_up_req_rdy: got %b want 00", up_req_rdy); end
    n_tests++; if (up_resp_val !== 2'b00) begin n_fail++; $display("FAIL rst_up_resp_val: got %b want 00", up_resp_val); end
    n_tests++; if (down_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_down_resp_rdy: got %b want 0", down_resp_rdy); end
    tick();
    idle();
    rst = 1'b1;
    req = mk_req(8'h11, 32'h40);
    up_req_val = 2'b01; up_req_msg[0] = req; down_req_rdy = 1'b1;
    #1;
    n_tests++; if (up_req_rdy !== 2'b01) begin n_fail++; $display("FAIL first_cycle_rdy: got %b want 01", up_req_rdy); end
    n_tests++; if (down_req_msg !== req) begin n_fail++; $display("FAIL first_cycle_msg: got %h want %h", down_req_msg, req); end
    tick();
    idle();
    rsp = mk_resp(8'h11, 32'h1234);
    down_resp_val = 1'b1; down_resp_msg = rsp; up_resp_rdy = 2'b11;
    #1;
    n_tests++; if (up_resp_val !== 2'b01) begin n_fail++; $display("FAIL first_resp_val: got %b want 01", up_resp_val); end
    n_tests++; if (up_resp_msg[0] !== rsp) begin n_fail++; $display("FAIL first_resp_msg: got %h want %h", up_resp_msg[0], rsp); end
    tick();
    idle();
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_port();
    logic [77:0] req;
    logic [47:0] rsp;
    req = mk_req(8'h05, 32'h100);
    rsp = mk_resp(8'h05, 32'hdeadbeef);
    up_req_val = 2'b10; up_req_msg[1] = req; up_req_msg[0] = mk_req(8'haa, 32'h999);
    down_req_rdy = 1'b1;
    #1;
    n_tests++; if (down_req_val !== 1'b1) begin n_fail++; $display("FAIL single_req_val: got %b want 1", down_req_val); end
    n_tests++; if (down_req_msg !== req) begin n_fail++; $display("FAIL single_req_msg: got %h want %h", down_req_msg, req); end
    n_tests++; if (up_req_rdy !== 2'b10) begin n_fail++; $display("FAIL single_req_rdy: got %b want 10", up_req_rdy); end
    tick();
    idle();
    tick();
    down_resp_val = 1'b1; down_resp_msg = rsp; up_resp_rdy = 2'b11;
    #1;
    n_tests++; if (up_resp_val !== 2'b10) begin n_fail++; $display("FAIL single_resp_val: got %b want 10", up_resp_val); end
    n_tests++; if (up_resp_msg[1] !== rsp) begin n_fail++; $display("FAIL single_resp_msg: got %h want %h", up_resp_msg[1], rsp); end
    n_tests++; if (down_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL single_resp_rdy: got %b want 1", down_resp_rdy); end
    tick();
    // FIFO now empty: a stray response must be refused.
    n_tests++; if (down_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL stray_resp_rdy: got %b want 0", down_resp_rdy); end
    n_tests++; if (up_resp_val !== 2'b00) begin n_fail++; $display("FAIL stray_resp_val: got %b want 00", up_resp_val); end
    tick();
    idle();
    $display("[TB] test_single_port done");
  endtask

  task automatic test_contention();
    logic [77:0] exp_req;
    logic [47:0] rsp;
    for (int c = 0; c < 4; c++) begin
      up_req_val = 2'b11; down_req_rdy = 1'b1;
      up_req_msg[0] = mk_req(8'h20 + 8'(c), 32'h1000 + 32'(c));
      up_req_msg[1] = mk_req(8'h30 + 8'(c), 32'h2000 + 32'(c));
      exp_req = (c % 2 == 1) ? mk_req(8'h30 + 8'(c), 32'h2000 + 32'(c))
                             : mk_req(8'h20 + 8'(c), 32'h1000 + 32'(c));
      #1;
      n_tests++; if (up_req_rdy !== onehot(c % 2)) begin n_fail++; $display("FAIL cont_grant%0d: got %b want %b", c, up_req_rdy, onehot(c % 2)); end
      n_tests++; if (down_req_msg !== exp_req) begin n_fail++; $display("FAIL cont_msg%0d: got %h want %h", c, down_req_msg, exp_req); end
      tick();
    end
    #1;
    n_tests++; if (down_req_val !== 1'b0) begin n_fail++; $display("FAIL cont_full_val: got %b want 0", down_req_val); end
    idle();
    for (int c = 0; c < 4; c++) begin
      rsp = mk_resp(((c % 2 == 1) ? 8'h30 : 8'h20) + 8'(c), 32'(c));
      down_resp_val = 1'b1; down_resp_msg = rsp; up_resp_rdy = 2'b11;
      #1;
      n_tests++; if (up_resp_val !== onehot(c % 2)) begin n_fail++; $display("FAIL cont_resp%0d: got %b want %b", c, up_resp_val, onehot(c % 2)); end
      n_tests++; if (up_resp_msg[c % 2] !== rsp) begin n_fail++; $display("FAIL cont_rmsg%0d: got %h want %h", c, up_resp_msg[c % 2], rsp); end
      tick();
    end
    idle();
    $display("[TB] test_contention done");
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      up_req_val = 2'b01; down_req_rdy = 1'b1; up_req_msg[0] = mk_req(8'h40 + 8'(k), 32'h300);
      #1;
      n_tests++; if (up_req_rdy !== 2'b01) begin n_fail++; $display("FAIL full_accept%0d: got %b want 01", k, up_req_rdy); end
      tick();
    end
    #1;
    n_tests++; if (up_req_rdy !== 2'b00) begin n_fail++; $display("FAIL full_block_rdy: got %b want 00", up_req_rdy); end
    n_tests++; if (down_req_val !== 1'b0) begin n_fail++; $display("FAIL full_block_val: got %b want 0", down_req_val); end
    down_resp_val = 1'b1; down_resp_msg = mk_resp(8'h40, 32'h0); up_resp_rdy = 2'b01;
    #1;
    n_tests++; if (down_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL full_pop_rdy: got %b want 1", down_resp_rdy); end
    n_tests++; if (up_req_rdy !== 2'b00) begin n_fail++; $display("FAIL full_no_bypass: got %b want 00", up_req_rdy); end
    tick();
    down_resp_val = 1'b0;
    #1;
    n_tests++; if (up_req_rdy !== 2'b01) begin n_fail++; $display("FAIL full_reaccept: got %b want 01", up_req_rdy); end
    tick();
    n_tests++; if (up_req_rdy !== 2'b00) begin n_fail++; $display("FAIL full_refull: got %b want 00", up_req_rdy); end
    up_req_val = 2'b00;
    for (int k = 0; k < 4; k++) begin
      down_resp_val = 1'b1;
      #1;
      n_tests++; if (up_resp_val !== 2'b01) begin n_fail++; $display("FAIL full_drain%0d: got %b want 01", k, up_resp_val); end
      tick();
    end
    idle();
    $display("[TB] test_full done");
  endtask

  task automatic test_wrap();
    int q[$];
    int p;
    int h;
    down_req_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      p = 1 - k;
      up_req_val = onehot(p); up_req_msg[p] = mk_req(8'h50, 32'h400);
      tick();
      q.push_back(p);
    end
    for (int i = 0; i < 10; i++) begin
      p = (i % 3 == 0) ? 1 : 0;
      h = q[0];
      up_req_val = onehot(p); up_req_msg[p] = mk_req(8'h60 + 8'(i), 32'h500);
      down_resp_val = 1'b1; down_resp_msg = mk_resp(8'h70 + 8'(i), 32'(i)); up_resp_rdy = 2'b11;
      #1;
      n_tests++; if (up_resp_val !== onehot(h)) begin n_fail++; $display("FAIL wrap_route%0d: got %b want %b", i, up_resp_val, onehot(h)); end
      n_tests++; if (up_req_rdy !== onehot(p)) begin n_fail++; $display("FAIL wrap_grant%0d: got %b want %b", i, up_req_rdy, onehot(p)); end
      tick();
      void'(q.pop_front());
      q.push_back(p);
    end
    up_req_val = 2'b00;
    for (int j = 0; j < 2; j++) begin
      h = q.pop_front();
      #1;
      n_tests++; if (up_resp_val !== onehot(h)) begin n_fail++; $display("FAIL wrap_drain%0d: got %b want %b", j, up_resp_val, onehot(h)); end
      tick();
    end
    n_tests++; if (down_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL wrap_count: got rdy %b want 0 after two drains", down_resp_rdy); end
    idle();
    $display("[TB] test_wrap done");
  endtask

  task automatic test_backpressure();
    up_req_val = 2'b01; down_req_rdy = 1'b1; up_req_msg[0] = mk_req(8'h80, 32'h600);
    tick();
    idle();
    down_resp_val = 1'b1; down_resp_msg = mk_resp(8'h80, 32'h77); up_resp_rdy = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (down_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy%0d: got %b want 0", k, down_resp_rdy); end
      n_tests++; if (up_resp_val !== 2'b01) begin n_fail++; $display("FAIL bp_val%0d: got %b want 01", k, up_resp_val); end
      tick();
    end
    up_resp_rdy = 2'b11;
    #1;
    n_tests++; if (down_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", down_resp_rdy); end
    tick();
    idle();
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      up_req_val = onehot(k % 2); down_req_rdy = 1'b1; up_req_msg[k % 2] = mk_req(8'h90 + 8'(k), 32'h700);
      tick();
    end
    up_req_val = 2'b11; down_req_rdy = 1'b1; down_resp_val = 1'b1; up_resp_rdy = 2'b11;
    #1;
    rst = 1'b0;
    #1;
    n_tests++; if (down_req_val !== 1'b0) begin n_fail++; $display("FAIL mid_req_val: got %b want 0", down_req_val); end
    n_tests++; if (up_req_rdy !== 2'b00) begin n_fail++; $display("FAIL mid_req_rdy: got %b want 00", up_req_rdy); end
    n_tests++; if (up_resp_val !== 2'b00) begin n_fail++; $display("FAIL mid_resp_val: got %b want 00", up_resp_val); end
    n_tests++; if (down_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_resp_rdy: got %b want 0", down_resp_rdy); end
    tick();
    rst = 1'b1;
    #1;
    n_tests++; if (up_req_rdy !== 2'b01) begin n_fail++; $display("FAIL mid_prio: got %b want 01", up_req_rdy); end
    n_tests++; if (down_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_empty: got %b want 0", down_resp_rdy); end
    down_resp_val = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      up_req_val = 2'b10;
      #1;
      n_tests++; if (up_req_rdy !== 2'b10) begin n_fail++; $display("FAIL mid_refill%0d: got %b want 10", k, up_req_rdy); end
      tick();
    end
    n_tests++; if (up_req_rdy !== 2'b00) begin n_fail++; $display("FAIL mid_count: got %b want 00 at four inflight", up_req_rdy); end
    idle();
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_port();
    test_contention();
    test_full();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
